// File: rtl/pipeline_reg_if_id_skid.sv
// IF/ID pipeline register with a 2-entry skid buffer (main + skid).
//
// The main entry drives decode. The skid entry catches the word accepted in the
// cycle that decode stalls. Because in_ready comes straight from a flop, it has
// no combinational path from out_ready. Flush kills both entries and inserts a
// NOP bubble.
//
// Optional feature: define IF_ID_PERF_EN to add saturating stall/flush counters.
//
// Ports:
//   clk, rst             rising-edge clock, asynchronous active-high reset
//   pcIn, instrIn        fetch payload, qualified by in_valid
//   in_valid, in_ready   fetch-side handshake (in_ready = !skid_valid)
//   flush                synchronous kill of held entries (redirect)
//   pcOut, instrOut      decode payload; instrOut = NOP_INSTR when !out_valid
//   out_valid, out_ready decode-side handshake (out_ready low = hazard stall)
//   stall_cnt, flush_cnt performance counters (IF_ID_PERF_EN only)

module pipeline_reg_if_id_skid #(
    parameter int unsigned         PC_W      = 32,
    parameter int unsigned         INSTR_W   = 32,
    parameter logic [INSTR_W-1:0]  NOP_INSTR = INSTR_W'(32'h0000_0013)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [PC_W-1:0]    pcIn,
    input  logic [INSTR_W-1:0] instrIn,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               flush,
    output logic [PC_W-1:0]    pcOut,
    output logic [INSTR_W-1:0] instrOut,
    output logic               out_valid,
    input  logic               out_ready
`ifdef IF_ID_PERF_EN
    ,
    output logic [31:0]        stall_cnt,
    output logic [31:0]        flush_cnt
`endif
);

    logic [PC_W-1:0]    pc_q, pc_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic               out_valid_q, out_valid_d;
    logic [PC_W-1:0]    skid_pc_q, skid_pc_d;
    logic [INSTR_W-1:0] skid_instr_q, skid_instr_d;
    logic               skid_valid_q, skid_valid_d;

    logic accept;
    logic drain;

    assign accept = in_valid & ~skid_valid_q;
    assign drain  = ~out_valid_q | out_ready;

    always_comb begin
        pc_d         = pc_q;
        instr_d      = instr_q;
        out_valid_d  = out_valid_q;
        skid_pc_d    = skid_pc_q;
        skid_instr_d = skid_instr_q;
        skid_valid_d = skid_valid_q;

        if (flush) begin
            pc_d         = '0;
            instr_d      = NOP_INSTR;
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (drain) begin
            if (skid_valid_q) begin
                // in_ready is low while the skid is full, so nothing is accepted here.
                pc_d         = skid_pc_q;
                instr_d      = skid_instr_q;
                out_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                pc_d        = pcIn;
                instr_d     = instrIn;
                out_valid_d = 1'b1;
            end else begin
                // Bubble: pcOut keeps its last value, only the instruction becomes a NOP.
                instr_d     = NOP_INSTR;
                out_valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_pc_d    = pcIn;
            skid_instr_d = instrIn;
            skid_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q         <= '0;
            instr_q      <= NOP_INSTR;
            out_valid_q  <= 1'b0;
            skid_pc_q    <= '0;
            skid_instr_q <= '0;
            skid_valid_q <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            instr_q      <= instr_d;
            out_valid_q  <= out_valid_d;
            skid_pc_q    <= skid_pc_d;
            skid_instr_q <= skid_instr_d;
            skid_valid_q <= skid_valid_d;
        end
    end

    assign pcOut     = pc_q;
    assign instrOut  = instr_q;
    assign out_valid = out_valid_q;
    assign in_ready  = ~skid_valid_q;

`ifdef IF_ID_PERF_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (out_valid_q && !out_ready && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
        if (flush && (flush_cnt_q != 32'hFFFF_FFFF)) begin
            flush_cnt_d = flush_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipeline_reg_if_id_skid.sv
module tb_pipeline_reg_if_id_skid;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic [31:0] pc_in;
    logic [31:0] instr_in;
    logic        in_valid;
    logic        in_ready;
    logic        flush;
    logic [31:0] pc_out;
    logic [31:0] instr_out;
    logic        out_valid;
    logic        out_ready;
`ifdef IF_ID_PERF_EN
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;
`endif

    pipeline_reg_if_id_skid dut (
        .clk       (clk),
        .rst       (rst),
        .pcIn      (pc_in),
        .instrIn   (instr_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .flush     (flush),
        .pcOut     (pc_out),
        .instrOut  (instr_out),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef IF_ID_PERF_EN
        ,
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [31:0] sb[$];

    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        return 32'hA000_0000 | (pc << 8) | 32'h33;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive a fetch word; if it is expected to be accepted, record it.
    task automatic drive(input logic [31:0] pc, input logic expect_accept);
        in_valid = 1'b1;
        pc_in    = pc;
        instr_in = instr_of(pc);
        if (expect_accept) sb.push_back(pc);
    endtask

    task automatic idle();
        in_valid = 1'b0;
        pc_in    = 32'hDEAD_BEEF;
        instr_in = 32'hDEAD_BEEF;
    endtask

    initial begin
        rst       = 1'b1;
        flush     = 1'b0;
        out_ready = 1'b0;
        idle();

        // Monitor: pops the scoreboard whenever decode consumes a word.
        fork
            begin
                logic [31:0] e;
                forever begin
                    @(negedge clk);
                    if (!rst) begin
                        if (out_valid && out_ready) begin
                            if (sb.size() == 0) begin
                                checks++;
                                errors++;
                                $display("FAIL sb_unexpected: got pc %h, required no output", pc_out);
                            end else begin
                                e = sb.pop_front();
                                chk("sb_pc", pc_out, e);
                                chk("sb_instr", instr_out, instr_of(e));
                            end
                        end else if (!out_valid) begin
                            chk("empty_nop", instr_out, NOP);
                        end
                    end
                end
            end
        join_none

        repeat (2) tick();
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_pc_out", pc_out, 32'd0);
        chk("rst_instr_out", instr_out, NOP);
        rst = 1'b0;
        tick();

        // 1: full-rate streaming, one-cycle latency
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(32'(i * 4), 1'b1);
            tick();
            chk("t1_pc", pc_out, 32'(i * 4));
            chk("t1_valid", {31'd0, out_valid}, 32'd1);
            chk("t1_in_ready", {31'd0, in_ready}, 32'd1);
        end

        // 5: no input -> bubble, pcOut holds
        idle();
        tick();
        chk("t5_valid", {31'd0, out_valid}, 32'd0);
        chk("t5_instr", instr_out, NOP);
        chk("t5_pc_hold", pc_out, 32'h8);

        // 2: backpressure fills skid, then drains in order
        out_ready = 1'b0;
        drive(32'h10, 1'b1);
        tick();
        chk("t2_pc_10", pc_out, 32'h10);
        chk("t2_rdy_a", {31'd0, in_ready}, 32'd1);
        drive(32'h14, 1'b1);
        tick();
        chk("t2_hold_10", pc_out, 32'h10);
        chk("t2_rdy_full", {31'd0, in_ready}, 32'd0);
        drive(32'h18, 1'b0);
        tick();
        chk("t2_stall_pc", pc_out, 32'h10);
        chk("t2_stall_rdy", {31'd0, in_ready}, 32'd0);
        out_ready = 1'b1;
        tick();
        chk("t2_pc_14", pc_out, 32'h14);
        chk("t2_rdy_back", {31'd0, in_ready}, 32'd1);
        drive(32'h18, 1'b1);
        tick();
        chk("t2_pc_18", pc_out, 32'h18);
        idle();
        tick();
        chk("t2_empty", {31'd0, out_valid}, 32'd0);

        // 3: flush with full skid and a word offered
        out_ready = 1'b0;
        drive(32'h30, 1'b1);
        tick();
        drive(32'h34, 1'b1);
        tick();
        chk("t3_full", {31'd0, in_ready}, 32'd0);
        drive(32'h20, 1'b0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        idle();
        sb.delete();
        chk("t3_valid", {31'd0, out_valid}, 32'd0);
        chk("t3_instr", instr_out, NOP);
        chk("t3_pc", pc_out, 32'd0);
        chk("t3_in_ready", {31'd0, in_ready}, 32'd1);
        // Flush beats a simultaneous accept into an empty stage.
        out_ready = 1'b1;
        drive(32'h24, 1'b0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        idle();
        chk("t3_acc_killed", {31'd0, out_valid}, 32'd0);
        tick();
        chk("t3_no_ghost", {31'd0, out_valid}, 32'd0);

        // 4: asynchronous reset while stalled with both entries full
        out_ready = 1'b0;
        drive(32'h40, 1'b1);
        tick();
        drive(32'h44, 1'b1);
        tick();
        idle();
        chk("t4_pre_full", {31'd0, in_ready}, 32'd0);
        #2;
        rst = 1'b1;
        #1;
        sb.delete();
        chk("t4_valid", {31'd0, out_valid}, 32'd0);
        chk("t4_in_ready", {31'd0, in_ready}, 32'd1);
        chk("t4_pc", pc_out, 32'd0);
        chk("t4_instr", instr_out, NOP);
        #1;
        rst = 1'b0;
        tick();
        chk("t4_after", {31'd0, out_valid}, 32'd0);

`ifdef IF_ID_PERF_EN
        // 6: five stall cycles and two flushes after a fresh reset
        rst = 1'b1;
        #2;
        rst = 1'b0;
        out_ready = 1'b0;
        drive(32'h50, 1'b1);
        tick();
        idle();
        repeat (5) tick();
        chk("t6_stall", stall_cnt, 32'd5);
        out_ready = 1'b1;
        tick();
        flush = 1'b1;
        repeat (2) tick();
        flush = 1'b0;
        chk("t6_flush", flush_cnt, 32'd2);
        chk("t6_stall_hold", stall_cnt, 32'd5);
`endif

        tick();
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
